pe_result_reader: RTL and testbench

//   Read-side counterpart of the PE result store. Holds the 32-bit result words a PE writes
//   (wr_en/wr_adr/wr_data, same write semantics as the PE memory). On start, drains words
//   0..num_words-1 as a byte stream over a valid/ready handshake, replacing the file dump

---
 rtl/pe_result_reader_pkg.sv | 22 ++
 rtl/pe_result_reader_if.sv | 29 ++
 rtl/pe_result_reader_mem.sv | 27 ++
 rtl/pe_result_reader.sv | 106 ++++++++++
 tb/tb_pe_result_reader.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/pe_result_reader_pkg.sv
// Shared constants, FSM state type and count clamp helper for the PE result reader.
package pe_result_reader_pkg;

  localparam int MAX_MEM_SIZE = 128;
  localparam int WORD_W       = 32;
  localparam int BYTE_W       = 8;
  localparam int ADR_W        = 8;
  localparam int MEM_AW       = $clog2(MAX_MEM_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  // Drain length never exceeds the number of words actually stored.
  function automatic logic [ADR_W-1:0] clamp_count(input logic [ADR_W-1:0] n);
    return (n > ADR_W'(MAX_MEM_SIZE)) ? ADR_W'(MAX_MEM_SIZE) : n;
  endfunction

endpackage

// File: rtl/pe_result_reader_if.sv
// Write port, drain control and byte-stream handshake of the PE result reader.
interface pe_result_reader_if;
  import pe_result_reader_pkg::*;

  logic              wr_en;
  logic [ADR_W-1:0]  wr_adr;
  logic [WORD_W-1:0] wr_data;
  logic              start;
  logic [ADR_W-1:0]  num_words;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;
  logic [ADR_W-1:0]  out_word_idx;
  logic [1:0]        out_byte_idx;

  modport master (
    output wr_en, wr_adr, wr_data, start, num_words, out_ready,
    input  busy, done, out_valid, out_data, out_last, out_word_idx, out_byte_idx
  );

  modport slave (
    input  wr_en, wr_adr, wr_data, start, num_words, out_ready,
    output busy, done, out_valid, out_data, out_last, out_word_idx, out_byte_idx
  );

endinterface

// File: rtl/pe_result_reader_mem.sv
// Result word store: one write port, one synchronous read-first read port.
module pe_result_reader_mem
  import pe_result_reader_pkg::*;
(
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADR_W-1:0]  i_wr_adr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [MEM_AW-1:0] i_rd_adr,
  output logic [WORD_W-1:0] o_rd_data
);

  logic [WORD_W-1:0] r_mem [MAX_MEM_SIZE];

  // NOTE: no reset on the array so it maps onto block RAM; contents survive rst.
  // Non-blocking read and write on the same edge give read-first behaviour.
  always_ff @(posedge clk) begin
    if (i_wr_en && (i_wr_adr < ADR_W'(MAX_MEM_SIZE))) begin
      r_mem[i_wr_adr[MEM_AW-1:0]] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= r_mem[i_rd_adr];
    end
  end

endmodule

// File: rtl/pe_result_reader.sv
// Drains stored PE result words 0..num_words-1 as a byte stream over valid/ready.
module pe_result_reader
  import pe_result_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  pe_result_reader_if.slave bus
);

  rd_state_t         r_state;
  logic [ADR_W-1:0]  r_count;
  logic [ADR_W-1:0]  r_ptr;
  logic [1:0]        r_byte_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_valid;
  logic              r_last;

  logic [WORD_W-1:0] w_word;
  logic              w_rd_en;
  logic              w_last_word;
  logic [ADR_W-1:0]  w_start_count;

  assign w_rd_en       = (r_state == FETCH);
  assign w_last_word   = (r_ptr == r_count - 1'b1);
  assign w_start_count = clamp_count(bus.num_words);

  // The RAM read register doubles as the word buffer; it only reloads in FETCH.
  pe_result_reader_mem u_mem (
    .clk       (clk),
    .i_wr_en   (bus.wr_en),
    .i_wr_adr  (bus.wr_adr),
    .i_wr_data (bus.wr_data),
    .i_rd_en   (w_rd_en),
    .i_rd_adr  (r_ptr[MEM_AW-1:0]),
    .o_rd_data (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_ptr      <= '0;
      r_byte_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_count <= w_start_count;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            if (w_start_count == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        FETCH: begin
          r_state    <= SEND;
          r_valid    <= 1'b1;
          r_byte_idx <= '0;
        end
        SEND: begin
          if (bus.out_ready) begin
            if (r_byte_idx == 2'd3) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              if (w_last_word) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_ptr   <= r_ptr + 1'b1;
                r_state <= FETCH;
              end
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_last     <= (r_byte_idx == 2'd2) && w_last_word;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Gated so the un-reset RAM register never leaks onto the bus while idle.
  assign bus.out_data     = r_valid ? w_word[{r_byte_idx, 3'b000} +: BYTE_W] : '0;
  assign bus.out_valid    = r_valid;
  assign bus.out_last     = r_last;
  assign bus.out_word_idx = r_ptr;
  assign bus.out_byte_idx = r_byte_idx;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_pe_result_reader.sv
// Randomized self-checking bench for pe_result_reader against a word-array reference model.
module tb_pe_result_reader;
  import pe_result_reader_pkg::*;

  logic clk;
  logic rst;
  pe_result_reader_if bus ();

  pe_result_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ref_mem [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_word(input int adr, input logic [31:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_adr  = 8'(adr);
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (adr < 128) ref_mem[adr] = data;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_busy"},  32'(bus.busy), 0);
    check({tag, "_done"},  32'(bus.done), 0);
    check({tag, "_last"},  32'(bus.out_last), 0);
    check({tag, "_data"},  32'(bus.out_data), 0);
  endtask

  // ready_mode: 0 always ready, 1 toggle 1,0,1,0, 2 random.
  task automatic run_drain(input int n, input int ready_mode, input bit mid_start,
                           input bit fetch_write, input logic [31:0] fetch_val);
    int cnt;
    int idx;
    int first_valid;
    int last_xfer;
    bit done_seen;
    bit stall;
    bit wrote;
    logic [7:0] st_data;
    logic [7:0] st_word;
    logic [1:0] st_byte;
    logic       st_last;
    logic [7:0] exp_q [$];

    cnt = (n > 128) ? 128 : n;
    for (int w = 0; w < cnt; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(ref_mem[w][8*b +: 8]);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_words = 8'(n);
    @(negedge clk);
    bus.start = 1'b0;

    idx = 0; first_valid = -1; last_xfer = -1;
    done_seen = 1'b0; stall = 1'b0; wrote = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) begin
      if (cyc > 0) @(negedge clk);
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (mid_start) begin
        if (cyc == 20) begin bus.start = 1'b1; bus.num_words = 8'd5; end
        else bus.start = 1'b0;
      end
      if (fetch_write) begin
        bus.wr_en = 1'b0;
        if (!wrote && idx == 4 && !bus.out_valid) begin
          bus.wr_en   = 1'b1;
          bus.wr_adr  = 8'd1;
          bus.wr_data = fetch_val;
          ref_mem[1]  = fetch_val;
          wrote       = 1'b1;
        end
      end

      if (stall) begin
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_data",  32'(bus.out_data), 32'(st_data));
        check("hold_word",  32'(bus.out_word_idx), 32'(st_word));
        check("hold_byte",  32'(bus.out_byte_idx), 32'(st_byte));
        check("hold_last",  32'(bus.out_last), 32'(st_last));
      end
      stall = 1'b0;
      check("busy_during", 32'(bus.busy), 1);

      if (bus.done) begin
        done_seen = 1'b1;
        check("done_count", idx, cnt * 4);
        check("valid_at_done", 32'(bus.out_valid), 0);
        if (cnt > 0) check("done_gap", cyc - last_xfer, 1);
      end else if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (idx >= cnt * 4) begin
          check("extra_valid", 32'(bus.out_valid), 0);
        end else if (bus.out_ready) begin
          check("data",     32'(bus.out_data), 32'(exp_q[idx]));
          check("word_idx", 32'(bus.out_word_idx), idx / 4);
          check("byte_idx", 32'(bus.out_byte_idx), idx % 4);
          check("last",     32'(bus.out_last), 32'(idx == cnt * 4 - 1));
          idx++;
          last_xfer = cyc;
        end else begin
          stall   = 1'b1;
          st_data = bus.out_data;
          st_word = bus.out_word_idx;
          st_byte = bus.out_byte_idx;
          st_last = bus.out_last;
        end
      end
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    check("done_seen", 32'(done_seen), 1);
    if (cnt > 0) check("first_valid_latency", first_valid, 1);
    @(negedge clk);
    check("busy_after", 32'(bus.busy), 0);
    check("done_after", 32'(bus.done), 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_adr    = '0;
    bus.wr_data   = '0;
    bus.start     = 1'b0;
    bus.num_words = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = 'x;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    check("reset_word_idx", 32'(bus.out_word_idx), 0);
    check("reset_byte_idx", 32'(bus.out_byte_idx), 0);
    rst = 1'b1;

    // Basic three-word drain, then the same with a stalling consumer.
    write_word(0, 32'h04030201);
    write_word(1, 32'h08070605);
    write_word(2, 32'h0C0B0A09);
    run_drain(3, 0, 1'b0, 1'b0, '0);
    run_drain(3, 1, 1'b0, 1'b0, '0);

    // Zero-length drain.
    run_drain(0, 0, 1'b0, 1'b0, '0);

    // Full memory, clamped count, start pulsed mid-drain.
    for (int i = 0; i < 128; i++) write_word(i, $urandom);
    run_drain(200, 0, 1'b1, 1'b0, '0);

    // Asynchronous reset mid-SEND; memory contents must survive.
    write_word(0, 32'h04030201);
    write_word(1, 32'h08070605);
    write_word(2, 32'h0C0B0A09);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.num_words = 8'd3;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", 32'(bus.out_valid), 1);
    #2 rst = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");
    run_drain(1, 0, 1'b0, 1'b0, '0);

    // Out-of-range write dropped; write during FETCH of word 1 is read-first.
    write_word(130, 32'hDEADBEEF);
    run_drain(3, 0, 1'b0, 1'b1, 32'hA5A5_5A5A);
    run_drain(3, 2, 1'b0, 1'b0, '0);

    // Random writes, counts and consumer back-pressure.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++) write_word($urandom_range(0, 140), $urandom);
      run_drain($urandom_range(1, 12), 2, 1'b0, 1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
